moldudp64_seq_check: RTL and testbench

- Sits directly downstream of the MoldUDP64 header field decoder and consumes its per-beat valid/field outputs.
- Reassembles the 80-bit session id, 64-bit sequence number and 16-bit message count spread over three header beats.
- Tracks the expected next sequence number per session and classifies each packet as in-order, gap, duplicate or overlap.
- Emits one registered verdict per packet to the message-extraction stage.

---
 rtl/moldudp64_seq_check_if.sv | 52 +++++
 rtl/moldudp64_seq_check.sv | 190 +++++++++++++++++++
 tb/tb_moldudp64_seq_check.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/moldudp64_seq_check_if.sv
// Header-beat inputs from the MoldUDP64 field decoder and the per-packet verdict outputs.
// The decoder drives the master side; the sequence checker sits on the slave side.
interface moldudp64_seq_check_if #(
    parameter int SID_W = 80,
    parameter int SEQ_W = 64,
    parameter int CNT_W = 16
);
    logic             flush_i;
    logic             sid_p0_v_i;
    logic [63:0]      sid_p0_i;
    logic             sid_p1_v_i;
    logic [15:0]      sid_p1_i;
    logic             seq_num_p0_v_i;
    logic [47:0]      seq_num_p0_i;
    logic             seq_num_p1_v_i;
    logic [15:0]      seq_num_p1_i;
    logic             msg_cnt_v_i;
    logic [CNT_W-1:0] msg_cnt_i;

    logic             hdr_v_o;
    logic [SID_W-1:0] sid_o;
    logic [SEQ_W-1:0] seq_num_o;
    logic [CNT_W-1:0] msg_cnt_o;
    logic [SEQ_W-1:0] exp_seq_o;
    logic             new_sess_o;
    logic             in_order_o;
    logic             gap_o;
    logic             dup_o;
    logic             overlap_o;
    logic [CNT_W-1:0] msg_skip_o;
    logic             heartbeat_o;
    logic             eos_o;
    logic             proto_err_o;

    modport master (
        output flush_i, sid_p0_v_i, sid_p0_i, sid_p1_v_i, sid_p1_i,
               seq_num_p0_v_i, seq_num_p0_i, seq_num_p1_v_i, seq_num_p1_i,
               msg_cnt_v_i, msg_cnt_i,
        input  hdr_v_o, sid_o, seq_num_o, msg_cnt_o, exp_seq_o, new_sess_o,
               in_order_o, gap_o, dup_o, overlap_o, msg_skip_o, heartbeat_o,
               eos_o, proto_err_o
    );

    modport slave (
        input  flush_i, sid_p0_v_i, sid_p0_i, sid_p1_v_i, sid_p1_i,
               seq_num_p0_v_i, seq_num_p0_i, seq_num_p1_v_i, seq_num_p1_i,
               msg_cnt_v_i, msg_cnt_i,
        output hdr_v_o, sid_o, seq_num_o, msg_cnt_o, exp_seq_o, new_sess_o,
               in_order_o, gap_o, dup_o, overlap_o, msg_skip_o, heartbeat_o,
               eos_o, proto_err_o
    );
endinterface

// File: rtl/moldudp64_seq_check.sv
// Reassembles the 3-beat MoldUDP64 header and classifies it against the per-session expected sequence.
// Verdict registered one cycle after beat 2; no backpressure, every beat is consumed the cycle it arrives.
module moldudp64_seq_check #(
    parameter int SID_W = 80,
    parameter int SEQ_W = 64,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic reset,
    moldudp64_seq_check_if.slave bus
);
    typedef enum logic [1:0] {IDLE, H0, H1} state_t;

    state_t           state, state_nxt;
    logic             cap0, cap1, eval, perr;
    logic             any_v;

    logic [63:0]      sid_hi;
    logic [15:0]      sid_lo;
    logic [47:0]      seq_hi;
    logic             sess_vld;
    logic [SID_W-1:0] sess_sid;
    logic [SEQ_W-1:0] exp_seq;

    logic [SID_W-1:0] sid_w;
    logic [SEQ_W-1:0] seq_w, end_w, exp_nxt;
    logic [CNT_W-1:0] cnt_w, skip_w;
    logic             new_w, ino_w, gap_w, dup_w, ovl_w, hb_w, eos_w;

    logic             hdr_v_q, perr_q;
    logic [SID_W-1:0] sid_q;
    logic [SEQ_W-1:0] seq_q, exp_q;
    logic [CNT_W-1:0] cnt_q, skip_q;
    logic             new_q, ino_q, gap_q, dup_q, ovl_q, hb_q, eos_q;

    assign any_v = bus.sid_p0_v_i | bus.sid_p1_v_i | bus.seq_num_p0_v_i
                 | bus.seq_num_p1_v_i | bus.msg_cnt_v_i;

    always_comb begin
        state_nxt = state;
        cap0      = 1'b0;
        cap1      = 1'b0;
        eval      = 1'b0;
        perr      = 1'b0;
        if (bus.flush_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.sid_p0_v_i) begin
                        cap0      = 1'b1;
                        state_nxt = H0;
                    end else if (any_v) begin
                        perr = 1'b1;
                    end
                end
                H0: begin
                    if (bus.sid_p1_v_i && bus.seq_num_p0_v_i) begin
                        cap1      = 1'b1;
                        state_nxt = H1;
                    end else if (bus.sid_p0_v_i) begin
                        cap0 = 1'b1;
                    end else if (any_v) begin
                        perr      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                H1: begin
                    if (bus.seq_num_p1_v_i && bus.msg_cnt_v_i) begin
                        eval      = 1'b1;
                        state_nxt = IDLE;
                    end else if (bus.sid_p0_v_i) begin
                        // A fresh beat 0 mid-header is an error but still starts the next header
                        perr      = 1'b1;
                        cap0      = 1'b1;
                        state_nxt = H0;
                    end else if (any_v) begin
                        perr      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign sid_w = {sid_hi, sid_lo};
    assign seq_w = {seq_hi, bus.seq_num_p1_i};
    assign cnt_w = bus.msg_cnt_i;
    assign end_w = seq_w + {{(SEQ_W-CNT_W){1'b0}}, cnt_w};
    assign hb_w  = (cnt_w == '0);
    assign eos_w = (cnt_w == '1);

    always_comb begin
        exp_nxt = exp_seq;
        new_w   = 1'b0;
        ino_w   = 1'b0;
        gap_w   = 1'b0;
        dup_w   = 1'b0;
        ovl_w   = 1'b0;
        skip_w  = '0;
        if (!sess_vld || sid_w != sess_sid) begin
            new_w = 1'b1;
            ino_w = 1'b1;
            if (!eos_w) exp_nxt = end_w;
        end else if (seq_w == exp_seq) begin
            ino_w = 1'b1;
            if (!eos_w) exp_nxt = end_w;
        end else if (seq_w > exp_seq) begin
            gap_w = 1'b1;
            if (!eos_w) exp_nxt = end_w;
        end else if (!hb_w) begin
            // Behind the expected point: fully stale or straddling it
            if (end_w <= exp_seq) begin
                dup_w = 1'b1;
            end else begin
                ovl_w  = 1'b1;
                skip_w = CNT_W'(exp_seq - seq_w);
                if (!eos_w) exp_nxt = end_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sid_hi   <= '0;
            sid_lo   <= '0;
            seq_hi   <= '0;
            sess_vld <= 1'b0;
            sess_sid <= '0;
            exp_seq  <= '0;
            hdr_v_q  <= 1'b0;
            perr_q   <= 1'b0;
            sid_q    <= '0;
            seq_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            skip_q   <= '0;
            new_q    <= 1'b0;
            ino_q    <= 1'b0;
            gap_q    <= 1'b0;
            dup_q    <= 1'b0;
            ovl_q    <= 1'b0;
            hb_q     <= 1'b0;
            eos_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            hdr_v_q <= eval;
            perr_q  <= perr;
            if (cap0) sid_hi <= bus.sid_p0_i;
            if (cap1) begin
                sid_lo <= bus.sid_p1_i;
                seq_hi <= bus.seq_num_p0_i;
            end
            if (eval) begin
                sess_sid <= sid_w;
                sess_vld <= !eos_w;
                exp_seq  <= exp_nxt;
                sid_q    <= sid_w;
                seq_q    <= seq_w;
                cnt_q    <= cnt_w;
                exp_q    <= exp_seq;
                skip_q   <= skip_w;
                new_q    <= new_w;
                ino_q    <= ino_w;
                gap_q    <= gap_w;
                dup_q    <= dup_w;
                ovl_q    <= ovl_w;
                hb_q     <= hb_w;
                eos_q    <= eos_w;
            end
        end
    end

    assign bus.hdr_v_o     = hdr_v_q;
    assign bus.proto_err_o = perr_q;
    assign bus.sid_o       = sid_q;
    assign bus.seq_num_o   = seq_q;
    assign bus.msg_cnt_o   = cnt_q;
    assign bus.exp_seq_o   = exp_q;
    assign bus.msg_skip_o  = skip_q;
    assign bus.new_sess_o  = new_q;
    assign bus.in_order_o  = ino_q;
    assign bus.gap_o       = gap_q;
    assign bus.dup_o       = dup_q;
    assign bus.overlap_o   = ovl_q;
    assign bus.heartbeat_o = hb_q;
    assign bus.eos_o       = eos_q;
endmodule

// File: tb/tb_moldudp64_seq_check.sv
// Directed bench for moldudp64_seq_check: drives header beats on negedges and checks verdicts there.
module tb_moldudp64_seq_check;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [79:0] SID_A = 80'h0000_0000_0000_0000_0001;
    localparam logic [79:0] SID_B = 80'h0123_4567_89AB_CDEF_0042;

    moldudp64_seq_check_if bus ();
    moldudp64_seq_check dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // {new_sess, in_order, gap, dup, overlap, heartbeat, eos}
    logic [6:0] flg;
    assign flg = {bus.new_sess_o, bus.in_order_o, bus.gap_o, bus.dup_o,
                  bus.overlap_o, bus.heartbeat_o, bus.eos_o};

    task automatic drive_idle();
        bus.flush_i        = 1'b0;
        bus.sid_p0_v_i     = 1'b0;
        bus.sid_p1_v_i     = 1'b0;
        bus.seq_num_p0_v_i = 1'b0;
        bus.seq_num_p1_v_i = 1'b0;
        bus.msg_cnt_v_i    = 1'b0;
    endtask

    task automatic beat0(input logic [79:0] sid);
        drive_idle();
        bus.sid_p0_v_i = 1'b1;
        bus.sid_p0_i   = sid[79:16];
    endtask

    task automatic beat1(input logic [79:0] sid, input logic [63:0] seq);
        drive_idle();
        bus.sid_p1_v_i     = 1'b1;
        bus.sid_p1_i       = sid[15:0];
        bus.seq_num_p0_v_i = 1'b1;
        bus.seq_num_p0_i   = seq[63:16];
    endtask

    task automatic beat2(input logic [63:0] seq, input logic [15:0] cnt);
        drive_idle();
        bus.seq_num_p1_v_i = 1'b1;
        bus.seq_num_p1_i   = seq[15:0];
        bus.msg_cnt_v_i    = 1'b1;
        bus.msg_cnt_i      = cnt;
    endtask

    // Returns on the negedge right after the beat-2 posedge, where the verdict is visible
    task automatic send_hdr(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt);
        @(negedge clk); beat0(sid);
        @(negedge clk); beat1(sid, seq);
        @(negedge clk); beat2(seq, cnt);
        @(negedge clk); drive_idle();
    endtask

    task automatic check_verdict(input string name, input logic [6:0] f,
                                 input logic [63:0] exp, input logic [15:0] skip);
        vectors++;
        if (bus.hdr_v_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s hdr_v: got %b want 1", name, bus.hdr_v_o);
        end
        vectors++;
        if (flg !== f) begin
            miscompares++;
            $display("FAIL %s flags: got %b want %b", name, flg, f);
        end
        vectors++;
        if (bus.exp_seq_o !== exp) begin
            miscompares++;
            $display("FAIL %s exp_seq: got %0d want %0d", name, bus.exp_seq_o, exp);
        end
        vectors++;
        if (bus.msg_skip_o !== skip) begin
            miscompares++;
            $display("FAIL %s msg_skip: got %0d want %0d", name, bus.msg_skip_o, skip);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        bus.sid_p0_i = '0; bus.sid_p1_i = '0; bus.seq_num_p0_i = '0;
        bus.seq_num_p1_i = '0; bus.msg_cnt_i = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.hdr_v_o, bus.proto_err_o, flg, bus.exp_seq_o, bus.sid_o, bus.seq_num_o,
             bus.msg_cnt_o, bus.msg_skip_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got hdr_v=%b perr=%b flags=%b exp=%0d want all 0",
                     bus.hdr_v_o, bus.proto_err_o, flg, bus.exp_seq_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_in_order();
        send_hdr(SID_A, 64'd100, 16'd3);
        check_verdict("first_pkt", 7'b1100000, 64'd0, 16'd0);
        vectors++;
        if (bus.sid_o !== SID_A || bus.seq_num_o !== 64'd100 || bus.msg_cnt_o !== 16'd3) begin
            miscompares++;
            $display("FAIL first_fields: got sid=%h seq=%0d cnt=%0d want %h 100 3",
                     bus.sid_o, bus.seq_num_o, bus.msg_cnt_o, SID_A);
        end
        @(negedge clk);
        vectors++;
        if (bus.hdr_v_o !== 1'b0 || flg !== 7'b1100000) begin
            miscompares++;
            $display("FAIL hold_after_pulse: got hdr_v=%b flags=%b want 0 1100000", bus.hdr_v_o, flg);
        end
        send_hdr(SID_A, 64'd103, 16'd2);
        check_verdict("in_order", 7'b0100000, 64'd103, 16'd0);
    endtask

    task automatic test_gap();
        send_hdr(SID_A, 64'd110, 16'd1);
        check_verdict("gap", 7'b0010000, 64'd105, 16'd0);
    endtask

    task automatic test_overlap_dup();
        send_hdr(SID_A, 64'd108, 16'd5);
        check_verdict("overlap", 7'b0000100, 64'd111, 16'd3);
        send_hdr(SID_A, 64'd109, 16'd2);
        check_verdict("dup", 7'b0001000, 64'd113, 16'd0);
    endtask

    task automatic test_heartbeat_eos();
        send_hdr(SID_A, 64'd113, 16'd0);
        check_verdict("heartbeat", 7'b0100010, 64'd113, 16'd0);
        send_hdr(SID_A, 64'd113, 16'hFFFF);
        check_verdict("eos", 7'b0100001, 64'd113, 16'd0);
        send_hdr(SID_A, 64'd113, 16'd1);
        check_verdict("after_eos", 7'b1100000, 64'd113, 16'd0);
    endtask

    task automatic test_proto_err();
        @(negedge clk); beat1(SID_A, 64'd0);
        @(negedge clk); drive_idle();
        vectors++;
        if (bus.proto_err_o !== 1'b1 || bus.hdr_v_o !== 1'b0) begin
            miscompares++;
            $display("FAIL proto_err_idle: got perr=%b hdr_v=%b want 1 0", bus.proto_err_o, bus.hdr_v_o);
        end
        @(negedge clk);
        vectors++;
        if (bus.proto_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL proto_err_pulse: got %b want 0", bus.proto_err_o);
        end
    endtask

    task automatic test_flush();
        // Flush coincident with beat 2 drops the header and leaves exp at 114
        @(negedge clk); beat0(SID_A);
        @(negedge clk); beat1(SID_A, 64'd114);
        @(negedge clk); beat2(64'd114, 16'd2); bus.flush_i = 1'b1;
        @(negedge clk); drive_idle();
        vectors++;
        if (bus.hdr_v_o !== 1'b0 || bus.proto_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_beat2: got hdr_v=%b perr=%b want 0 0", bus.hdr_v_o, bus.proto_err_o);
        end
        // Flush on an idle H1 cycle returns to IDLE, so a late beat 2 is an error
        @(negedge clk); beat0(SID_A);
        @(negedge clk); beat1(SID_A, 64'd114);
        @(negedge clk); drive_idle(); bus.flush_i = 1'b1;
        @(negedge clk); beat2(64'd114, 16'd2);
        vectors++;
        if (bus.proto_err_o !== 1'b0 || bus.hdr_v_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_h1: got perr=%b hdr_v=%b want 0 0", bus.proto_err_o, bus.hdr_v_o);
        end
        @(negedge clk); drive_idle();
        vectors++;
        if (bus.proto_err_o !== 1'b1 || bus.hdr_v_o !== 1'b0) begin
            miscompares++;
            $display("FAIL beat2_after_flush: got perr=%b hdr_v=%b want 1 0", bus.proto_err_o, bus.hdr_v_o);
        end
        send_hdr(SID_A, 64'd114, 16'd2);
        check_verdict("post_flush", 7'b0100000, 64'd114, 16'd0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk); beat0(SID_A);
        @(negedge clk); beat1(SID_A, 64'd116);
        @(negedge clk); beat2(64'd116, 16'd1); reset = 1'b1;
        @(negedge clk); drive_idle(); reset = 1'b0;
        vectors++;
        if (bus.hdr_v_o !== 1'b0 || bus.exp_seq_o !== 64'd0 || flg !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got hdr_v=%b exp=%0d flags=%b want 0 0 0000000",
                     bus.hdr_v_o, bus.exp_seq_o, flg);
        end
        send_hdr(SID_A, 64'd116, 16'd1);
        check_verdict("after_reset", 7'b1100000, 64'd0, 16'd0);
    endtask

    task automatic test_back_to_back();
        // Repeated beat 0 restarts capture without an error; the later sid wins
        @(negedge clk); beat0(80'hFFFF_FFFF_FFFF_FFFF_0000);
        @(negedge clk); beat0(SID_B);
        @(negedge clk); beat1(SID_B, 64'h0001_0000_0000_0005);
        vectors++;
        if (bus.proto_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_no_err: got %b want 0", bus.proto_err_o);
        end
        @(negedge clk); beat2(64'h0001_0000_0000_0005, 16'd4);
        @(negedge clk); drive_idle();
        check_verdict("restart", 7'b1100000, 64'd117, 16'd0);
        vectors++;
        if (bus.sid_o !== SID_B || bus.seq_num_o !== 64'h0001_0000_0000_0005) begin
            miscompares++;
            $display("FAIL restart_fields: got sid=%h seq=%h want %h 0001000000000005",
                     bus.sid_o, bus.seq_num_o, SID_B);
        end
        send_hdr(SID_B, 64'h0001_0000_0000_0009, 16'd1);
        check_verdict("b2b_in_order", 7'b0100000, 64'h0001_0000_0000_0009, 16'd0);
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_gap();
        test_overlap_dup();
        test_heartbeat_eos();
        test_proto_err();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
